prog_clock_divider: RTL and testbench
=====================================

# prog_clock_divider

Multi-channel programmable clock-enable/divided-clock generator. It is the parametrised successor of the fixed single-output divider. Each of `NCH` channels derives a divided output from `clk_in` with a run-time divisor, a run-time high time (duty cycle), a per-channel enable and a one-cycle period-start tick. Divisor and duty updates are double-buffered and take effect only at a period boundary, so outputs never glitch or produce runt periods. The block sits in the clocking area and feeds timer, PWM and slow-peripheral logic.

## Interface
- `NCH`, 2, number of independent channels
- `CW`, 16, width of the divisor and high-time fields
- `DEF_DIV`, 8, reset period in `clk_in` cycles per channel (must be ≥2)
- `DEF_HI`, 4, reset high time in cycles per channel
- `clk_in` input 1: the block's only clock; all logic on rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `en` input NCH: per-channel run enable, level-sensitive
- `div_ld` input NCH: per-channel one-cycle load strobe for new settings
- `div_val` input NCH*CW: packed period values; channel i = bits [i*CW +: CW]
- `hi_val` input NCH*CW: packed high-time values, same packing
- `clk_out` output NCH: registered divided output per channel
- `tick` output NCH: registered one-cycle pulse on the first cycle of each period
- `upd_pend` output NCH: high while a loaded setting waits for a period boundary

## Operation
- Each channel holds the following state:
  - active registers `per_a`, `hi_a`
  - shadow registers `per_s`, `hi_s` with a `pend` flag
  - counter `cnt` (CW bits)
  - `run` flag
- Period clamp: the effective period is `max(per, 2)`. Values 0 and 1 behave as 2.
- Duty rules, applied on the effective period:
  - `clk_out` is high while `cnt < hi`.
  - `hi == 0` gives a constant-low output.
  - `hi ≥ period` gives a constant-high output.
  - `tick` still fires every period in both constant cases.
- Load: `div_ld[i]` captures the `div_val`/`hi_val` slices into the shadow registers and sets `pend`. A later load before the boundary overwrites the shadow (newest wins).
- Boundary: a boundary edge is either the wrap edge (`run` && `en` && `cnt == per_a-1`) or the start edge (`!run` && `en`). At a boundary edge, if `pend` or `div_ld` is set:
  - The active registers take the shadow value. A load arriving on that same edge is used directly.
  - `pend` clears.
  - The new values govern the period that starts at this edge.
- States per channel:
  - IDLE (`run=0`)
    - IDLE→RUN when `en=1`: `cnt←0`, `tick←1`, `clk_out←(0<hi)`.
  - RUN (`run=1`), `en=1`:
    - `cnt` advances; at `per_a-1` it wraps to 0.
    - `tick←(next cnt==0)`, `clk_out←(next cnt<hi_a)`.
  - RUN→IDLE when `en=0`: on the next edge `cnt←0`, `clk_out←0`, `tick←0`.
    - The stop is abrupt, with no period completion.
    - A pending update is applied on the next start edge.
- Loads are accepted in either state. While IDLE, a loaded value is applied at the next start edge.
- Channels are fully independent. No cross-channel phase relation is guaranteed unless they are enabled on the same edge with equal settings, in which case their outputs are identical.
- Arithmetic: all compares are unsigned, CW bits wide. There is no overflow: `cnt` never exceeds `per_a-1`.

## Timing
- Reset (asynchronous, immediate):
  - `clk_out=0`, `tick=0`, `upd_pend=0`, `cnt=0`, `run=0`
  - `per_a=per_s=DEF_DIV`, `hi_a=hi_s=DEF_HI`
- Reset asserted mid-operation forces these values regardless of `en`/`div_ld`. Operation restarts from IDLE after release.
- Latency:
  - `en` sampled high at edge k gives `tick=1` and the first `clk_out` level after edge k.
  - `en` sampled low at edge k gives `clk_out=0` after edge k.
- `upd_pend` rises the cycle after a non-boundary load and falls after the boundary edge. It never rises if the load coincides with a boundary edge.
- A steady period of P cycles gives `tick` exactly once every P cycles and `clk_out` high for `min(hi,P)` cycles per period.
- With `en` held high, no period is shortened or lengthened by a load; only whole periods change.

## Test plan
- Reset, `en[0]=1`, default settings: `clk_out[0]` runs 4 high / 4 low repeating, `tick[0]` every 8th cycle coincident with the rising edge; `upd_pend=0`.
- Load `div_val=5`, `hi_val=2` at `cnt=3` of an 8-cycle period: the current period completes 8 cycles, then periods are 5 cycles (2 high / 3 low); `upd_pend` is high from the load until the wrap.
- Load `hi=0`, then `hi=9` with period 8: constant low, then constant high, with `tick` still every 8 cycles. Load `div_val=0` or `1`: period 2, 1 high / 1 low with `hi=1`.
- Drop `en` mid-period: `clk_out=0` and `tick=0` on the next cycle. Re-assert `en`: `tick` on the first cycle and a fresh full period. A load made while disabled takes effect at restart.
- Assert `rst_n=0` mid-period with a load pending: outputs go to 0 immediately; after release, defaults are restored and the pending load is discarded.
- Two channels with different settings and interleaved loads/enables: each matches its own model with no cross-coupling. Equal settings enabled on the same edge give identical `clk_out`.

Source files
------------

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: per-channel period/high-time with
// double-buffered updates applied only at period boundaries.

module prog_clock_divider_ch #(
  parameter int CW      = 16,
  parameter int DEF_DIV = 8,
  parameter int DEF_HI  = 4
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          en,
  input  logic          div_ld,
  input  logic [CW-1:0] div_val,
  input  logic [CW-1:0] hi_val,
  output logic          clk_out,
  output logic          tick,
  output logic          upd_pend
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_per_a, r_hi_a, r_per_s, r_hi_s, r_cnt;
  logic          r_pend, r_clk, r_tick;

  logic [CW-1:0] w_per_n, w_hi_n, w_cnt_n;
  logic          w_last, w_bnd, w_apply, w_tick_n, w_clk_n;

  // Periods below 2 cannot hold both a high and a low phase.
  function automatic logic [CW-1:0] clamp_per(input logic [CW-1:0] p);
    return (p < CW'(2)) ? CW'(2) : p;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_last    = (r_cnt == r_per_a - CW'(1));
    w_bnd     = 1'b0;
    w_cnt_n   = '0;
    case (r_state)
      IDLE: begin
        w_bnd = en;
        if (en) w_state_n = RUN;
      end
      RUN: begin
        w_bnd = en && w_last;
        if (!en)         w_state_n = IDLE;
        else if (!w_last) w_cnt_n  = r_cnt + CW'(1);
      end
      default: w_state_n = IDLE;
    endcase

    // A load on the boundary edge itself bypasses the shadow.
    w_apply = w_bnd && (r_pend || div_ld);
    w_per_n = r_per_a;
    w_hi_n  = r_hi_a;
    if (w_apply) begin
      w_per_n = clamp_per(div_ld ? div_val : r_per_s);
      w_hi_n  = div_ld ? hi_val : r_hi_s;
    end

    w_tick_n = en && (w_cnt_n == '0);
    w_clk_n  = en && (w_cnt_n < w_hi_n);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_per_a <= CW'(DEF_DIV);
      r_hi_a  <= CW'(DEF_HI);
      r_per_s <= CW'(DEF_DIV);
      r_hi_s  <= CW'(DEF_HI);
      r_pend  <= 1'b0;
      r_cnt   <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_per_a <= w_per_n;
      r_hi_a  <= w_hi_n;
      if (div_ld) begin
        r_per_s <= div_val;
        r_hi_s  <= hi_val;
      end
      if (w_apply)     r_pend <= 1'b0;
      else if (div_ld) r_pend <= 1'b1;
      r_cnt  <= w_cnt_n;
      r_clk  <= w_clk_n;
      r_tick <= w_tick_n;
    end
  end

  assign clk_out  = r_clk;
  assign tick     = r_tick;
  assign upd_pend = r_pend;

endmodule

module prog_clock_divider #(
  parameter int NCH     = 2,
  parameter int CW      = 16,
  parameter int DEF_DIV = 8,
  parameter int DEF_HI  = 4
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NCH-1:0]    en,
  input  logic [NCH-1:0]    div_ld,
  input  logic [NCH*CW-1:0] div_val,
  input  logic [NCH*CW-1:0] hi_val,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    upd_pend
);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    prog_clock_divider_ch #(
      .CW      (CW),
      .DEF_DIV (DEF_DIV),
      .DEF_HI  (DEF_HI)
    ) u_ch (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .en       (en[gi]),
      .div_ld   (div_ld[gi]),
      .div_val  (div_val[gi*CW +: CW]),
      .hi_val   (hi_val[gi*CW +: CW]),
      .clk_out  (clk_out[gi]),
      .tick     (tick[gi]),
      .upd_pend (upd_pend[gi])
    );
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: expected per-cycle waveforms are
// hand-written strings per channel ('1'/'0' for clk_out, tick, upd_pend).

module tb_prog_clock_divider;
  localparam int NCH = 2;
  localparam int CW  = 16;

  logic              clk_in = 1'b0;
  logic              rst_n  = 1'b1;
  logic [NCH-1:0]    en     = '0;
  logic [NCH-1:0]    div_ld = '0;
  logic [NCH*CW-1:0] div_val = '0;
  logic [NCH*CW-1:0] hi_val  = '0;
  logic [NCH-1:0]    clk_out, tick, upd_pend;

  int nerr = 0;
  int nchk = 0;

  prog_clock_divider #(.NCH(NCH), .CW(CW), .DEF_DIV(8), .DEF_HI(4)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .div_ld   (div_ld),
    .div_val  (div_val),
    .hi_val   (hi_val),
    .clk_out  (clk_out),
    .tick     (tick),
    .upd_pend (upd_pend)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic string z(input int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, "0"};
    return s;
  endfunction

  task automatic ld(input int ch, input int per, input int hi);
    div_ld[ch]             = 1'b1;
    div_val[ch*CW +: CW]   = CW'(per);
    hi_val[ch*CW +: CW]    = CW'(hi);
  endtask

  // One string character per clock edge; load strobes drop after the first edge.
  task automatic run(input string nm,
                     input string c0, input string t0, input string p0,
                     input string c1, input string t1, input string p1);
    for (int i = 0; i < c0.len(); i++) begin
      @(posedge clk_in);
      #1;
      if (i == 0) div_ld = '0;
      chk($sformatf("%s[%0d] ch0 clk_out", nm, i),  clk_out[0],  c0[i] == "1");
      chk($sformatf("%s[%0d] ch0 tick", nm, i),     tick[0],     t0[i] == "1");
      chk($sformatf("%s[%0d] ch0 upd_pend", nm, i), upd_pend[0], p0[i] == "1");
      chk($sformatf("%s[%0d] ch1 clk_out", nm, i),  clk_out[1],  c1[i] == "1");
      chk($sformatf("%s[%0d] ch1 tick", nm, i),     tick[1],     t1[i] == "1");
      chk($sformatf("%s[%0d] ch1 upd_pend", nm, i), upd_pend[1], p1[i] == "1");
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset clk_out",  |clk_out,  1'b0);
    chk("reset tick",     |tick,     1'b0);
    chk("reset upd_pend", |upd_pend, 1'b0);
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    run("idle", z(3), z(3), z(3), z(3), z(3), z(3));

    // Default 8/4 after enabling channel 0.
    en[0] = 1'b1;
    run("def", "1111000011110000", "1000000010000000", z(16), z(16), z(16), z(16));
    run("def2", "1111", "1000", z(4), z(4), z(4), z(4));

    // Mid-period load at cnt=3: current period completes, then 5/2.
    ld(0, 5, 2);
    run("ld52a", "0000", "0000", "1111", z(4), z(4), z(4));
    run("ld52b", "1100011000", "1000010000", z(10), z(10), z(10), z(10));

    // Loads landing on the wrap edge apply directly, upd_pend never rises.
    ld(0, 8, 0);
    run("hi0", "00000000", "10000000", z(8), z(8), z(8), z(8));
    ld(0, 8, 9);
    run("hi9", "11111111", "10000000", z(8), z(8), z(8), z(8));
    ld(0, 1, 1);
    run("div1", "101010", "101010", z(6), z(6), z(6), z(6));
    ld(0, 0, 1);
    run("div0", "1010", "1010", z(4), z(4), z(4), z(4));
    ld(0, 8, 4);
    run("back", "111", "100", z(3), z(3), z(3), z(3));

    // Drop enable mid-period, load while idle, restart.
    en[0] = 1'b0;
    run("stop", "00", "00", "00", z(2), z(2), z(2));
    ld(0, 6, 3);
    run("idle_ld", "000", "000", "111", z(3), z(3), z(3));
    en[0] = 1'b1;
    run("restart", "111000111000", "100000100000", z(12), z(12), z(12), z(12));

    // Reset mid-period with a pending load.
    run("pre_rst", "11", "10", "00", z(2), z(2), z(2));
    ld(0, 3, 1);
    run("pend", "1", "0", "1", z(1), z(1), z(1));
    rst_n = 1'b0;
    #2;
    chk("async rst clk_out",  clk_out[0],  1'b0);
    chk("async rst tick",     tick[0],     1'b0);
    chk("async rst upd_pend", upd_pend[0], 1'b0);
    @(posedge clk_in); #1;
    run("in_rst", z(2), z(2), z(2), z(2), z(2), z(2));
    rst_n = 1'b1;
    run("post_rst", "1111000011110000", "1000000010000000", z(16), z(16), z(16), z(16));

    // Two channels: equal settings enabled together, then independent loads.
    en = 2'b00;
    run("both_off", "0", "0", "0", "0", "0", "0");
    ld(0, 6, 2);
    ld(1, 6, 2);
    run("both_ld", "0", "0", "1", "0", "0", "1");
    en = 2'b11;
    run("both_on", "110000110000", "100000100000", z(12),
                   "110000110000", "100000100000", z(12));
    ld(1, 3, 1);
    run("ch1_31", "110000", "100000", z(6), "100100", "100100", z(6));
    run("ch_adv", "11", "10", "00", "10", "10", "00");
    ld(0, 4, 3);
    en[1] = 1'b0;
    run("ch0_ld", "0000", "0000", "1111", z(4), z(4), z(4));
    run("ch0_43", "11101110", "10001000", z(8), z(8), z(8), z(8));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
